// File: rtl/alu_issue_if.sv
// Bundle of the two requester channels, the ALU drive/result lines and the
// response/status outputs of the ALU issue arbiter.
interface alu_issue_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic [3:0]        req0_opcode;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic              req0_ready;

    logic              req1_valid;
    logic [3:0]        req1_opcode;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic              req1_ready;

    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovfl;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [2:0]        flags;
    logic              halted;

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_op1, req1_op2,
        output req1_ready,
        output alu_opcode, alu_op1, alu_op2,
        input  alu_out, alu_ovfl,
        output rsp_valid,
        input  rsp_ready,
        output rsp_id, rsp_data, flags, halted
    );

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_op1, req1_op2,
        input  req1_ready,
        input  alu_opcode, alu_op1, alu_op2,
        output alu_out, alu_ovfl,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_id, rsp_data, flags, halted
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Two-requester arbiter in front of a single-cycle ALU: picks a winner, drives
// the ALU, buffers one response and keeps the Z/N/V flags and the halt latch.
module alu_issue_arbiter #(
    parameter int DATA_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic              rsp_vld_p1;
    logic              rsp_id_p1;
    logic [DATA_W-1:0] rsp_data_p1;
    logic [2:0]        flags_p1;
    logic              halt_p1;
    logic              rr_ptr;

    logic              any_vld;
    logic              sel1;
    logic [1:0]        mode;
    logic              can_issue;
    logic              xfer;

    function automatic logic [2:0] upd_flags(input logic [3:0]        op,
                                             input logic [DATA_W-1:0] res,
                                             input logic              ovfl,
                                             input logic [2:0]        cur);
        logic [2:0] nf;
        logic       z;
        nf = cur;
        z  = (res == '0);
        case (op)
            OP_ADD, OP_SUB:                 nf = {ovfl, res[DATA_W-1], z};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: nf = {cur[2:1], z};
            default:                        nf = cur;
        endcase
        return nf;
    endfunction

    // Winner selection and ALU drive (combinational)
    always_comb begin
        any_vld = bus.req0_valid || bus.req1_valid;
        sel1    = bus.req1_valid && (!bus.req0_valid || ((RR_EN != 1'b0) && rr_ptr));
        if (!any_vld) begin
            bus.alu_opcode = '0;
            bus.alu_op1    = '0;
            bus.alu_op2    = '0;
        end else if (sel1) begin
            bus.alu_opcode = bus.req1_opcode;
            bus.alu_op1    = bus.req1_op1;
            bus.alu_op2    = bus.req1_op2;
        end else begin
            bus.alu_opcode = bus.req0_opcode;
            bus.alu_op1    = bus.req0_op1;
            bus.alu_op2    = bus.req0_op2;
        end
    end

    // HOLD is a full buffer the consumer is not taking; HALT overrides everything.
    always_comb begin
        if (halt_p1)
            mode = ST_HALT;
        else if (rsp_vld_p1 && !bus.rsp_ready)
            mode = ST_HOLD;
        else
            mode = ST_RUN;
    end

    assign can_issue      = (mode == ST_RUN);
    assign xfer           = can_issue && any_vld;
    assign bus.req0_ready = can_issue && bus.req0_valid && !sel1;
    assign bus.req1_ready = can_issue && sel1;

    // Response buffer, flags, halt latch and priority pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_p1  <= 1'b0;
            rsp_id_p1   <= 1'b0;
            rsp_data_p1 <= '0;
            flags_p1    <= 3'b000;
            halt_p1     <= 1'b0;
            rr_ptr      <= 1'b0;
        end else if (xfer) begin
            rsp_vld_p1  <= 1'b1;
            rsp_id_p1   <= sel1;
            rsp_data_p1 <= bus.alu_out;
            flags_p1    <= upd_flags(bus.alu_opcode, bus.alu_out, bus.alu_ovfl, flags_p1);
            rr_ptr      <= ~sel1;
            if (bus.alu_opcode == OP_HLT)
                halt_p1 <= 1'b1;
        end else if (rsp_vld_p1 && bus.rsp_ready) begin
            rsp_vld_p1  <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_vld_p1;
    assign bus.rsp_id    = rsp_id_p1;
    assign bus.rsp_data  = rsp_data_p1;
    assign bus.flags     = flags_p1;
    assign bus.halted    = halt_p1;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: vector table, hand-written corner sequences and
// a randomized run against a transaction-level reference model.
module tb_alu_issue_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(16)) bus();

    alu_issue_arbiter #(.DATA_W(16), .RR_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ALU returning {overflow, result}
    function automatic logic [16:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        logic [31:0] t;
        r = a & b;
        v = 1'b0;
        t = {a, a} >> b[3:0];
        case (op)
            4'd0:    begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1:    begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2:    r = a ^ b;
            4'd4:    r = a << b[3:0];
            4'd5:    r = 16'($signed(a) >>> b[3:0]);
            4'd6:    r = t[15:0];
            4'd10:   r = {a[15:8], b[7:0]};
            default: r = a & b;
        endcase
        return {v, r};
    endfunction

    function automatic logic [2:0] ref_flags(input logic [3:0] op, input logic [15:0] r, input logic v, input logic [2:0] cur);
        if (op == 4'd0 || op == 4'd1) return {v, r[15], (r == 16'd0)};
        if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return {cur[2:1], (r == 16'd0)};
        return cur;
    endfunction

    logic [16:0] alu_res;
    always_comb begin
        alu_res      = ref_alu(bus.alu_opcode, bus.alu_op1, bus.alu_op2);
        bus.alu_out  = alu_res[15:0];
        bus.alu_ovfl = alu_res[16];
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic [2:0]  fl;
    } vec_t;

    vec_t tbl[10];

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_opcode = '0; bus.req0_op1 = '0; bus.req0_op2 = '0;
        bus.req1_valid = 1'b0; bus.req1_opcode = '0; bus.req1_op1 = '0; bus.req1_op2 = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #4 rst = 1'b0;
    endtask

    task automatic drive0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req0_valid = 1'b1; bus.req0_opcode = op; bus.req0_op1 = a; bus.req0_op2 = b;
    endtask

    task automatic drive1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req1_valid = 1'b1; bus.req1_opcode = op; bus.req1_op1 = a; bus.req1_op2 = b;
    endtask

    // Random-run model state
    logic        m_v, m_id, m_ptr;
    logic [15:0] m_data;
    logic [2:0]  m_fl;
    logic        pend0, pend1;
    logic        can, win1, xf;
    logic [16:0] res;
    logic [35:0] exp_drive;

    initial begin
        tbl[0] = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110};
        tbl[1] = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 3'b001};
        tbl[2] = '{4'hA, 16'h1200, 16'h0034, 16'h1234, 3'b001};
        tbl[3] = '{4'h2, 16'h00FF, 16'h00F0, 16'h000F, 3'b000};
        tbl[4] = '{4'h0, 16'h8000, 16'h8000, 16'h0000, 3'b101};
        tbl[5] = '{4'h4, 16'h0001, 16'h000F, 16'h8000, 3'b100};
        tbl[6] = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 3'b010};
        tbl[7] = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b010};
        tbl[8] = '{4'h5, 16'h8000, 16'h0004, 16'hF800, 3'b010};
        tbl[9] = '{4'h3, 16'h0F0F, 16'h00FF, 16'h000F, 3'b010};

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_id",    64'(bus.rsp_id),    64'(0));
        chk("reset_rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("reset_flags",     64'(bus.flags),     64'(0));
        chk("reset_halted",    64'(bus.halted),    64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Vector table: single requester, consumer always ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive0(tbl[i].op, tbl[i].a, tbl[i].b);
            bus.rsp_ready = 1'b1;
            #1 chk($sformatf("tbl%0d_ready0", i), 64'(bus.req0_ready), 64'(1));
            @(negedge clk);
            bus.req0_valid = 1'b0;
            chk($sformatf("tbl%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(1));
            chk($sformatf("tbl%0d_rsp_id", i),    64'(bus.rsp_id),    64'(0));
            chk($sformatf("tbl%0d_rsp_data", i),  64'(bus.rsp_data),  64'(tbl[i].data));
            chk($sformatf("tbl%0d_flags", i),     64'(bus.flags),     64'(tbl[i].fl));
        end

        // Round robin with both requesters always valid
        do_reset();
        @(negedge clk);
        drive0(4'h0, 16'h0001, 16'h0001);
        drive1(4'h0, 16'h0002, 16'h0002);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_ready0", k), 64'(bus.req0_ready), 64'(k % 2 == 0));
            chk($sformatf("rr%0d_ready1", k), 64'(bus.req1_ready), 64'(k % 2 == 1));
            if (k > 0) begin
                chk($sformatf("rr%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'(1));
                chk($sformatf("rr%0d_rsp_id", k),    64'(bus.rsp_id),    64'((k - 1) % 2));
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_last_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("rr_last_rsp_id",    64'(bus.rsp_id),    64'(1));

        // Response stall, then release
        do_reset();
        @(negedge clk);
        drive0(4'h0, 16'h7FFF, 16'h0001);
        #1 chk("stall_first_ready0", 64'(bus.req0_ready), 64'(1));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        drive1(4'h2, 16'h00FF, 16'h00FF);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready1", k), 64'(bus.req1_ready), 64'(0));
            chk($sformatf("stall%0d_rsp_data", k), 64'(bus.rsp_data), 64'(16'h8000));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("release_ready1", 64'(bus.req1_ready), 64'(1));
        @(negedge clk);
        bus.req1_valid = 1'b0;
        chk("release_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("release_rsp_id",   64'(bus.rsp_id),   64'(1));
        chk("release_flags",    64'(bus.flags),    64'(3'b111));

        // HLT from requester 0 while requester 1 keeps asking
        do_reset();
        @(negedge clk);
        drive1(4'h0, 16'h7FFF, 16'h0001);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        drive0(4'hF, 16'h00F0, 16'h0FF0);
        #1;
        chk("hlt_ready0", 64'(bus.req0_ready), 64'(1));
        chk("hlt_ready1", 64'(bus.req1_ready), 64'(0));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        chk("hlt_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("hlt_rsp_id",    64'(bus.rsp_id),    64'(0));
        chk("hlt_rsp_data",  64'(bus.rsp_data),  64'(16'h00F0));
        chk("hlt_halted",    64'(bus.halted),    64'(1));
        chk("hlt_flags",     64'(bus.flags),     64'(3'b110));
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.rsp_ready = 1'b1;
            #1 chk($sformatf("halted%0d_ready1", k), 64'(bus.req1_ready), 64'(0));
            @(negedge clk);
        end
        chk("hlt_drained", 64'(bus.rsp_valid), 64'(0));
        chk("hlt_still_halted", 64'(bus.halted), 64'(1));
        #2 rst = 1'b1;
        #1 chk("hlt_async_clear", 64'(bus.halted), 64'(0));
        #1 rst = 1'b0;

        // Asynchronous reset while a response is stalled
        do_reset();
        @(negedge clk);
        drive0(4'h0, 16'h7FFF, 16'h0001);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk("arst_pre_valid", 64'(bus.rsp_valid), 64'(1));
        chk("arst_pre_flags", 64'(bus.flags),     64'(3'b110));
        #2 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("arst_flags",     64'(bus.flags),     64'(0));
        chk("arst_halted",    64'(bus.halted),    64'(0));
        #1 rst = 1'b0;

        // Randomized run against the transaction-level model
        do_reset();
        m_v = 1'b0; m_id = 1'b0; m_ptr = 1'b0; m_data = '0; m_fl = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk($sformatf("rand%0d_vld_flags", c), 64'({bus.rsp_valid, bus.flags}), 64'({m_v, m_fl}));
            if (m_v)
                chk($sformatf("rand%0d_id_data", c), 64'({bus.rsp_id, bus.rsp_data}), 64'({m_id, m_data}));
            if (!pend0) begin
                bus.req0_valid  = ($urandom_range(0, 2) != 0);
                bus.req0_opcode = 4'($urandom_range(0, 14));
                bus.req0_op1    = 16'($urandom);
                bus.req0_op2    = 16'($urandom);
            end
            if (!pend1) begin
                bus.req1_valid  = ($urandom_range(0, 2) != 0);
                bus.req1_opcode = 4'($urandom_range(0, 14));
                bus.req1_op1    = 16'($urandom);
                bus.req1_op2    = 16'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            can  = !m_v || bus.rsp_ready;
            win1 = bus.req1_valid && (!bus.req0_valid || m_ptr);
            chk($sformatf("rand%0d_ready", c), 64'({bus.req0_ready, bus.req1_ready}),
                64'({can && bus.req0_valid && !win1, can && win1}));
            if (!bus.req0_valid && !bus.req1_valid)
                exp_drive = '0;
            else if (win1)
                exp_drive = {bus.req1_opcode, bus.req1_op1, bus.req1_op2};
            else
                exp_drive = {bus.req0_opcode, bus.req0_op1, bus.req0_op2};
            chk($sformatf("rand%0d_drive", c), 64'({bus.alu_opcode, bus.alu_op1, bus.alu_op2}), 64'(exp_drive));
            xf = can && (bus.req0_valid || bus.req1_valid);
            if (xf) begin
                res    = ref_alu(exp_drive[35:32], exp_drive[31:16], exp_drive[15:0]);
                m_fl   = ref_flags(exp_drive[35:32], res[15:0], res[16], m_fl);
                m_v    = 1'b1;
                m_id   = win1;
                m_data = res[15:0];
                m_ptr  = !win1;
            end else if (m_v && bus.rsp_ready) begin
                m_v = 1'b0;
            end
            pend0 = bus.req0_valid && !(xf && !win1);
            pend1 = bus.req1_valid && !(xf && win1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single-cycle 16-bit ALU between two requesters, e.g. the execute stage and a PC/address helper.
- Arbitrates between the requesters with round-robin priority and drives the ALU opcode and operands from the winner.
- Captures the ALU result into a one-entry response buffer with backpressure, and owns the architectural Z/N/V flag register.
- Sits between the decode/issue logic and the ALU.

Parameters:
- DATA_W, 16, operand and result width; only 16 is supported.
- RR_EN, 1, 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 always winning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_opcode  in  4  ALU opcode for requester 0.
- req0_op1  in  16  operand 1 for requester 0.
- req0_op2  in  16  operand 2 for requester 0.
- req0_ready  out  1  grant to requester 0; transfer occurs when valid && ready.
- req1_valid, req1_opcode, req1_op1, req1_op2, req1_ready  as for requester 0.
- alu_opcode  out  4  opcode driven to the ALU.
- alu_op1  out  16  operand 1 driven to the ALU.
- alu_op2  out  16  operand 2 driven to the ALU.
- alu_out  in  16  combinational ALU result.
- alu_ovfl  in  1  combinational ALU overflow for ADD/SUB.
- rsp_valid  out  1  response buffer is full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  16  registered ALU result.
- flags  out  3  [2]=V, [1]=N, [0]=Z.
- halted  out  1  sticky; set once a HLT has been issued.

Behaviour:
- Reset (asynchronous, active-high) forces: rsp_valid=0, rsp_id=0, rsp_data=0, flags=0, halted=0, priority pointer=0 (requester 0 favoured).
- can_issue = !halted && (!rsp_valid || rsp_ready).
- Winner selection:
  - Only one valid requester: it wins.
  - Both valid, RR_EN=1: the pointer selects the winner.
  - Both valid, RR_EN=0: requester 0 wins.
- reqN_ready = can_issue && winner==N; it is combinational, with at most one ready high per cycle.
- ALU drive is combinational:
  - alu_opcode/op1/op2 come from the winner's payload whenever at least one request is valid, even if can_issue=0.
  - With no request valid, all three are 0.
- Issue edge (a transfer occurs):
  - rsp_data<=alu_out, rsp_id<=winner, rsp_valid<=1.
  - The pointer moves to the requester that did not win.
  - Latency is 1 cycle: the response is visible in the cycle after the transfer.
- Response drain:
  - rsp_valid && rsp_ready with no transfer: rsp_valid<=0.
  - Drain and transfer on the same edge: the new response replaces the old one with no bubble.
- Hold: while rsp_valid && !rsp_ready, no grants are made; rsp_* stays stable and the pointer is unchanged.
- Requesters must hold valid and payload stable until ready; the block does not check this.
- Flag update, on the transfer edge only, from alu_out/alu_ovfl:
  - ADD (0000), SUB (0001): Z, N and V all update.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; N and V hold.
  - All other opcodes: flags hold.
  - Z = (alu_out==0), N = alu_out[15], V = alu_ovfl.
- HLT (1111):
  - It is issued and responded to like any other opcode.
  - halted<=1 on the same edge.
  - From the next cycle no further grants are made until reset.
  - A response that is already buffered still drains normally.
- Mode summary (FSM):
  - RUN: halted=0, buffer empty or draining; grants allowed.
  - HOLD: buffer full and rsp_ready=0; RUN->HOLD when the buffer is full and rsp_ready=0.
  - HALT: halted=1; entered on a HLT transfer and left only by reset.
- Reset mid-operation clears the buffered response immediately; the lost transaction is not replayed.
- Opcodes are not validated; every 4-bit value is issued.

Test Plan:
- Reset, then req0 ADD 0x7FFF+0x0001 with rsp_ready=1:
  - req0_ready=1 in cycle 0.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data=0x8000, flags=3'b110.
- Both requesters valid every cycle, rsp_ready=1, RR_EN=1, four transfers:
  - Grants go 0,1,0,1.
  - rsp_id sequence is 0,1,0,1 on consecutive cycles with no bubble.
- Response stall:
  - Setup: hold rsp_ready=0 for 3 cycles with req1 valid carrying XOR 0x00FF^0x00FF.
  - Response: req1_ready=0 throughout and rsp_data is unchanged.
  - Release: raising rsp_ready grants req1 on that cycle, followed by rsp_data=0x0000 and flags[0]=1, with N and V unchanged.
- Flags held across LLB:
  - After a SUB 5-5 (flags=001), issue LLB 0x1234.
  - flags stay 001 and rsp_data equals alu_out.
- HLT from req0 with req1 still valid:
  - One response is produced with rsp_id=0.
  - halted=1 from the next cycle; req1_ready stays 0 indefinitely.
  - Asserting rst clears halted and rsp_valid asynchronously.
- Asynchronous reset mid-stall:
  - Assert rst between clock edges while rsp_valid=1.
  - rsp_valid, flags and halted go to 0 without waiting for a clock edge.
